// File: rtl/aes_pkg.sv
// Shared types and helpers for the AES-128 key-expansion slice.
// Word/block types, round count, FSM states and byte helpers.
package aes_pkg;

    typedef logic [31:0]  word_t;
    typedef logic [127:0] block_t;

    localparam int NR = 10;

    typedef enum logic {
        S_IDLE,
        S_EXPAND
    } state_e;

    // GF(2^8) multiply by x, reduced by the AES polynomial
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Rotate a word left by one byte
    function automatic word_t rotword(input word_t w);
        return {w[23:0], w[31:24]};
    endfunction

endpackage

// File: rtl/aes_key_expand_if.sv
// Request/status and round-key read bundle for aes_key_expand.
// The design side uses the slave modport, the requester the master.
interface aes_key_expand_if;
    import aes_pkg::*;

    logic       start;
    block_t     key;
    logic       busy;
    logic       done;
    logic       keys_valid;
    logic [3:0] rk_idx;
    block_t     rk;

    modport master (
        output start, key, rk_idx,
        input  busy, done, keys_valid, rk
    );

    modport slave (
        input  start, key, rk_idx,
        output busy, done, keys_valid, rk
    );

endinterface

// File: rtl/aes_key_expand_key_round.sv
// One AES-128 key-schedule step: previous round key to next round key.
// Purely combinational; feeds the key file once per cycle.
module key_round
    import aes_pkg::*;
(
    input  block_t     prev,
    input  logic [7:0] rcon,
    output block_t     next
);

    word_t w0, w1, w2, w3;
    word_t sub, t;
    word_t n0, n1, n2, n3;

    assign {w0, w1, w2, w3} = prev;

    osubword u_sub (
        .dir  (1'b0),
        .din  (rotword(w3)),
        .dout (sub)
    );

    // Xor chain: each new word folds in the one produced before it
    always_comb begin
        t    = sub ^ {rcon, 24'h0};
        n0   = w0 ^ t;
        n1   = w1 ^ n0;
        n2   = w2 ^ n1;
        n3   = w3 ^ n2;
        next = {n0, n1, n2, n3};
    end

endmodule

// File: rtl/osubword.sv
// Byte-wise AES S-box on a 32-bit word.
// dir=0 forward S-box, dir=1 inverse S-box; computed via GF inversion.
module osubword
    import aes_pkg::*;
(
    input  logic  dir,
    input  word_t din,
    output word_t dout
);

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // a^254 is the multiplicative inverse, with 0 mapping to 0
    function automatic logic [7:0] ginv(input logic [7:0] a);
        logic [7:0] r;
        logic [7:0] s;
        r = 8'h01;
        s = a;
        for (int i = 1; i < 8; i++) begin
            s = gmul(s, s);
            r = gmul(r, s);
        end
        return r;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        logic [15:0] d;
        d = {b, b} << n;
        return d[15:8];
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] b);
        logic [7:0] v;
        v = ginv(b);
        return v ^ rotl8(v, 1) ^ rotl8(v, 2) ^ rotl8(v, 3) ^ rotl8(v, 4) ^ 8'h63;
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] b);
        logic [7:0] v;
        v = rotl8(b, 1) ^ rotl8(b, 3) ^ rotl8(b, 6) ^ 8'h05;
        return ginv(v);
    endfunction

    // Substitute each byte independently in the selected direction
    always_comb begin
        dout = '0;
        for (int i = 0; i < 4; i++) begin
            dout[8*i +: 8] = dir ? inv_sbox(din[8*i +: 8])
                                 : sbox(din[8*i +: 8]);
        end
    end

endmodule

// File: rtl/aes_key_expand.sv
// Sequential AES-128 key expansion into an 11-entry round-key file.
// One round key per cycle; file read combinationally by index.
module aes_key_expand
    import aes_pkg::*;
#(
    parameter int NR = aes_pkg::NR
) (
    input logic            clk,
    input logic            reset_n,
    aes_key_expand_if.slave bus
);

    if (NR != 10) begin : g_nr_check
        $error("aes_key_expand supports only NR=10");
    end

    state_e     state_q, state_d;
    logic [3:0] rnd_q;
    logic [7:0] rcon_q;
    block_t     rk_q [0:10];
    logic       done_q, done_d;
    logic       kv_q, kv_d;
    logic       accept;
    logic       expand;
    logic       last;
    block_t     rk_next;

    key_round u_round (
        .prev (rk_q[rnd_q - 4'd1]),
        .rcon (rcon_q),
        .next (rk_next)
    );

    // FSM state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

    // Next-state: start only counts in IDLE, leave EXPAND after round 10
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:   if (bus.start) state_d = S_EXPAND;
            S_EXPAND: if (rnd_q == 4'd10) state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Outputs and registered status next-values
    always_comb begin
        accept   = (state_q == S_IDLE) && bus.start;
        expand   = (state_q == S_EXPAND);
        last     = expand && (rnd_q == 4'd10);
        bus.busy = expand;
        done_d   = last;
        kv_d     = kv_q;
        if (accept) kv_d = 1'b0;
        if (last)   kv_d = 1'b1;
    end

    // Status flags
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            done_q <= 1'b0;
            kv_q   <= 1'b0;
        end else begin
            done_q <= done_d;
            kv_q   <= kv_d;
        end
    end

    // Round counter, rcon and key file writes
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rnd_q  <= 4'd0;
            rcon_q <= 8'h01;
            for (int i = 0; i <= 10; i++) rk_q[i] <= '0;
        end else if (accept) begin
            rk_q[0] <= bus.key;
            rnd_q   <= 4'd1;
            rcon_q  <= 8'h01;
        end else if (expand) begin
            rk_q[rnd_q] <= rk_next;
            rcon_q      <= xtime(rcon_q);
            rnd_q       <= last ? 4'd0 : rnd_q + 4'd1;
        end
    end

    // Combinational read port; indices past the file read as zero
    always_comb begin
        bus.rk = '0;
        if (bus.rk_idx <= 4'd10) bus.rk = rk_q[bus.rk_idx];
    end

    assign bus.done       = done_q;
    assign bus.keys_valid = kv_q;

endmodule

// File: tb/tb_aes_key_expand.sv
// Directed bench for aes_key_expand: table of round-key vectors
// plus timing, interrupt, re-key, reset and back-to-back sequences.
module tb_aes_key_expand;
    import aes_pkg::*;

    logic clk;
    logic reset_n;

    aes_key_expand_if bus ();

    aes_key_expand #(.NR(10)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam block_t FIPS = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam block_t ZERO = 128'h0;

    typedef struct {
        block_t     key;
        logic [3:0] idx;
        block_t     exp;
        string      name;
    } vec_t;

    vec_t vecs [$];
    int   n_chk;
    int   n_pass;
    block_t loaded;
    logic   have_loaded;

    task automatic chk(input string name, input logic [127:0] act,
                       input logic [127:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic run_expand(input block_t k, input string tag);
        int cyc;
        @(negedge clk);
        bus.start = 1'b1;
        bus.key   = k;
        @(negedge clk);
        bus.start = 1'b0;
        bus.key   = ~k;
        cyc = 1;
        while (!bus.done && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        chk({tag, "_latency"}, 128'(cyc), 128'd11);
        chk({tag, "_kv"}, 128'(bus.keys_valid), 128'd1);
    endtask

    task automatic read_rk(input logic [3:0] idx, input string name,
                           input block_t exp);
        bus.rk_idx = idx;
        #1;
        chk(name, bus.rk, exp);
    endtask

    initial begin
        int k;
        int ndone;
        int first_done;
        int kv_hi;
        int d_at [$];

        n_chk       = 0;
        n_pass      = 0;
        have_loaded = 1'b0;
        loaded      = '0;
        reset_n     = 1'b0;
        bus.start   = 1'b0;
        bus.key     = '0;
        bus.rk_idx  = 4'd0;

        vecs.push_back('{FIPS, 4'd0,  FIPS, "fips_rk0"});
        vecs.push_back('{FIPS, 4'd1,  128'ha0fafe1788542cb123a339392a6c7605, "fips_rk1"});
        vecs.push_back('{FIPS, 4'd2,  128'hf2c295f27a96b9435935807a7359f67f, "fips_rk2"});
        vecs.push_back('{FIPS, 4'd10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6, "fips_rk10"});
        vecs.push_back('{FIPS, 4'd11, 128'h0, "fips_idx11"});
        vecs.push_back('{FIPS, 4'd15, 128'h0, "fips_idx15"});
        vecs.push_back('{ZERO, 4'd1,  128'h62636363626363636263636362636363, "zero_rk1"});
        vecs.push_back('{ZERO, 4'd2,  128'h9b9898c9f9fbfbaa9b9898c9f9fbfbaa, "zero_rk2"});
        vecs.push_back('{ZERO, 4'd10, 128'hb4ef5bcb3e92e21123e951cf6f8f188e, "zero_rk10"});

        repeat (2) @(negedge clk);
        chk("rst_busy", 128'(bus.busy), 128'd0);
        chk("rst_done", 128'(bus.done), 128'd0);
        chk("rst_kv", 128'(bus.keys_valid), 128'd0);
        reset_n = 1'b1;
        @(negedge clk);
        read_rk(4'd0, "rst_rk0", 128'h0);

        // Table-driven round-key checks
        foreach (vecs[i]) begin
            if (!have_loaded || loaded !== vecs[i].key) begin
                run_expand(vecs[i].key, "tbl");
                loaded      = vecs[i].key;
                have_loaded = 1'b1;
            end
            read_rk(vecs[i].idx, vecs[i].name, vecs[i].exp);
        end

        // Exact timing of busy/done, and start ignored mid-expansion
        @(negedge clk);
        bus.start = 1'b1;
        bus.key   = FIPS;
        ndone      = 0;
        first_done = 0;
        for (k = 1; k <= 25; k++) begin
            @(negedge clk);
            bus.start = (k == 3);
            bus.key   = (k == 3) ? ZERO : FIPS;
            if (k == 1) chk("t1_busy", 128'(bus.busy), 128'd1);
            if (k == 11) chk("t11_busy", 128'(bus.busy), 128'd0);
            if (bus.done) begin
                ndone++;
                if (first_done == 0) first_done = k;
            end
        end
        bus.start = 1'b0;
        chk("intr_done_cnt", 128'(ndone), 128'd1);
        chk("intr_done_at", 128'(first_done), 128'd11);
        read_rk(4'd1, "intr_rk1", 128'ha0fafe1788542cb123a339392a6c7605);
        read_rk(4'd10, "intr_rk10", 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

        // Re-key from FIPS to zero key
        @(negedge clk);
        bus.start = 1'b1;
        bus.key   = ZERO;
        kv_hi = 0;
        for (k = 1; k <= 11; k++) begin
            @(negedge clk);
            bus.start = 1'b0;
            if (k <= 10 && bus.keys_valid) kv_hi++;
        end
        chk("rekey_kv_low", 128'(kv_hi), 128'd0);
        chk("rekey_kv_high", 128'(bus.keys_valid), 128'd1);
        read_rk(4'd1, "rekey_rk1", 128'h62636363626363636263636362636363);
        read_rk(4'd10, "rekey_rk10", 128'hb4ef5bcb3e92e21123e951cf6f8f188e);

        // Asynchronous reset in the middle of an expansion
        @(negedge clk);
        bus.start = 1'b1;
        bus.key   = FIPS;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (4) @(negedge clk);
        #2;
        reset_n    = 1'b0;
        bus.rk_idx = 4'd0;
        #1;
        chk("mid_rst_busy", 128'(bus.busy), 128'd0);
        chk("mid_rst_kv", 128'(bus.keys_valid), 128'd0);
        chk("mid_rst_done", 128'(bus.done), 128'd0);
        chk("mid_rst_rk0", bus.rk, 128'h0);
        @(negedge clk);
        reset_n = 1'b1;
        run_expand(FIPS, "post_rst");
        read_rk(4'd10, "post_rst_rk10", 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

        // start held high: done every 11 cycles
        @(negedge clk);
        bus.start = 1'b1;
        bus.key   = FIPS;
        for (k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (bus.done) d_at.push_back(k);
        end
        bus.start = 1'b0;
        chk("b2b_cnt", 128'(d_at.size()), 128'd3);
        if (d_at.size() >= 3) begin
            chk("b2b_gap1", 128'(d_at[1] - d_at[0]), 128'd11);
            chk("b2b_gap2", 128'(d_at[2] - d_at[1]), 128'd11);
        end
        k = 0;
        while (!bus.keys_valid && k < 40) begin
            @(negedge clk);
            k++;
        end
        chk("b2b_settle_kv", 128'(bus.keys_valid), 128'd1);
        read_rk(4'd10, "b2b_rk10", 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
